// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard control for the MIPS32 five-stage pipe.
//
// Produces the per-stage write-enables and synchronous flushes for the
// Fetch/Decode/Execute/Memory pipe registers. It handles load-use hazards,
// MULT/DIV occupancy, data-memory wait and taken branches.
//
// Parameters:
//   MD_LAT  MULT/DIV result latency in cycles (2..63)
//   CNT_W   width of the MULT/DIV busy counter (2**CNT_W > MD_LAT)
//
// Ports:
//   i_clk, i_a_rst_n       clock (rising edge), async active-low reset
//   i_s_rst                synchronous clear, same effect as reset
//   i_instr_dec/_exec      instructions held in the Decode/Execute registers
//   i_branch_taken_exec    branch/jump in Execute resolved taken
//   i_mem_busy             data memory not ready; freezes the whole pipe
//   o_we_*                 pipe register write-enables
//   o_flush_dec/_exec      synchronous clears (Execute bubble = NOP)
//   o_md_busy              MULT/DIV unit occupied
//   o_state                current FSM state (RUN/MD_WAIT/MEM_WAIT/LU_STALL)
//   o_stall_cnt            stall-cycle counter
//
// Build option: define HAZ_PERF_CNT_EN to build the saturating stall-cycle
// counter. Without it, o_stall_cnt is tied to zero and has no flops.

module hazard_ctrl #(
    parameter int unsigned MD_LAT = 32,
    parameter int unsigned CNT_W  = 6
) (
    input  logic        i_clk,
    input  logic        i_a_rst_n,
    input  logic        i_s_rst,
    input  logic [31:0] i_instr_dec,
    input  logic [31:0] i_instr_exec,
    input  logic        i_branch_taken_exec,
    input  logic        i_mem_busy,
    output logic        o_we_fetch,
    output logic        o_we_dec,
    output logic        o_we_exec,
    output logic        o_we_mem,
    output logic        o_flush_dec,
    output logic        o_flush_exec,
    output logic        o_md_busy,
    output logic [1:0]  o_state,
    output logic [31:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_WAIT  = 2'd1,
        MEM_WAIT = 2'd2,
        LU_STALL = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;

    // Instruction field decode
    logic [5:0] op_d, op_e, funct_d, funct_e;
    logic [4:0] rs_d, rt_d, rt_e;

    assign op_d    = i_instr_dec[31:26];
    assign rs_d    = i_instr_dec[25:21];
    assign rt_d    = i_instr_dec[20:16];
    assign funct_d = i_instr_dec[5:0];
    assign op_e    = i_instr_exec[31:26];
    assign rt_e    = i_instr_exec[20:16];
    assign funct_e = i_instr_exec[5:0];

    // Fields that hazard detection never looks at
    logic unused_fields;
    assign unused_fields = ^{i_instr_exec[25:21], i_instr_exec[15:6], i_instr_dec[15:6]};

    function automatic logic is_md_op(input logic [5:0] op, input logic [5:0] funct);
        return (op == 6'h00) &&
               (funct == 6'h18 || funct == 6'h19 || funct == 6'h1A || funct == 6'h1B);
    endfunction

    logic load_e, dec_reads_rt, hilo_rd_d, md_op_d, md_op_e;
    logic lu, mdh;

    always_comb begin
        load_e = (op_e == 6'h20 || op_e == 6'h21 || op_e == 6'h23 ||
                  op_e == 6'h24 || op_e == 6'h25) && (rt_e != 5'd0);
        dec_reads_rt = (op_d == 6'h00 || op_d == 6'h04 || op_d == 6'h05 ||
                        op_d == 6'h28 || op_d == 6'h29 || op_d == 6'h2B);
        hilo_rd_d = (op_d == 6'h00) && (funct_d == 6'h10 || funct_d == 6'h12);
        md_op_d   = is_md_op(op_d, funct_d);
        md_op_e   = is_md_op(op_e, funct_e);
        // Once the bubble is in, the load-use hazard is not re-raised: the
        // LU_STALL state masks it so the stall lasts exactly one cycle.
        lu  = load_e && (rt_e == rs_d || (dec_reads_rt && rt_e == rt_d)) &&
              (state_q != LU_STALL);
        mdh = (md_cnt_q != '0) && (hilo_rd_d || md_op_d);
    end

    // Priority resolution: reset > memory freeze > branch > mdh > lu > run
    always_comb begin
        o_we_fetch   = 1'b1;
        o_we_dec     = 1'b1;
        o_we_exec    = 1'b1;
        o_we_mem     = 1'b1;
        o_flush_dec  = 1'b0;
        o_flush_exec = 1'b0;
        state_d      = RUN;

        if (!i_a_rst_n || i_s_rst) begin
            o_we_fetch = 1'b0;
            o_we_dec   = 1'b0;
            o_we_exec  = 1'b0;
            o_we_mem   = 1'b0;
        end else if (i_mem_busy) begin
            o_we_fetch = 1'b0;
            o_we_dec   = 1'b0;
            o_we_exec  = 1'b0;
            o_we_mem   = 1'b0;
            state_d    = MEM_WAIT;
        end else if (i_branch_taken_exec) begin
            o_flush_dec  = 1'b1;
            o_flush_exec = 1'b1;
        end else if (mdh) begin
            o_we_fetch   = 1'b0;
            o_we_dec     = 1'b0;
            o_flush_exec = 1'b1;
            state_d      = MD_WAIT;
        end else if (lu) begin
            o_we_fetch   = 1'b0;
            o_we_dec     = 1'b0;
            o_flush_exec = 1'b1;
            state_d      = LU_STALL;
        end
    end

    // MULT/DIV occupancy: loaded when the MD op leaves Execute, then counts
    // down every cycle, memory freeze included.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (i_s_rst) begin
            md_cnt_d = '0;
        end else if (o_we_mem && md_op_e) begin
            md_cnt_d = CNT_W'(MD_LAT - 1);
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            state_q  <= RUN;
            md_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            md_cnt_q <= md_cnt_d;
        end
    end

    assign o_md_busy = (md_cnt_q != '0);
    assign o_state   = state_q;

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (i_s_rst) begin
            stall_cnt_d = '0;
        end else if (!o_we_fetch && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_a_rst_n) begin
        if (!i_a_rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`else
    assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_rst;
    logic [31:0] instr_dec;
    logic [31:0] instr_exec;
    logic        br_taken;
    logic        mem_busy;
    logic        we_fetch, we_dec, we_exec, we_mem;
    logic        flush_dec, flush_exec;
    logic        md_busy;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .MD_LAT(32),
        .CNT_W (6)
    ) dut (
        .i_clk              (clk),
        .i_a_rst_n          (rst_n),
        .i_s_rst            (s_rst),
        .i_instr_dec        (instr_dec),
        .i_instr_exec       (instr_exec),
        .i_branch_taken_exec(br_taken),
        .i_mem_busy         (mem_busy),
        .o_we_fetch         (we_fetch),
        .o_we_dec           (we_dec),
        .o_we_exec          (we_exec),
        .o_we_mem           (we_mem),
        .o_flush_dec        (flush_dec),
        .o_flush_exec       (flush_exec),
        .o_md_busy          (md_busy),
        .o_state            (state),
        .o_stall_cnt        (stall_cnt)
    );

    // {we_fetch, we_dec, we_exec, we_mem, flush_dec, flush_exec}
    logic [5:0] ctl;
    assign ctl = {we_fetch, we_dec, we_exec, we_mem, flush_dec, flush_exec};

    localparam logic [5:0] CTL_OFF   = 6'b000000;
    localparam logic [5:0] CTL_RUN   = 6'b111100;
    localparam logic [5:0] CTL_STALL = 6'b001101;
    localparam logic [5:0] CTL_BR    = 6'b111111;

    localparam logic [31:0] NOP     = 32'h0000_0000;
    localparam logic [31:0] LW_T0   = {6'h23, 5'd29, 5'd8, 16'h0004};
    localparam logic [31:0] LW_ZERO = {6'h23, 5'd29, 5'd0, 16'h0004};
    localparam logic [31:0] ADD_RS8 = {6'h00, 5'd8, 5'd9, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] ADD_RS0 = {6'h00, 5'd0, 5'd9, 5'd10, 5'd0, 6'h20};
    localparam logic [31:0] SW_RT8  = {6'h2B, 5'd29, 5'd8, 16'h0000};
    localparam logic [31:0] ADDI_8  = {6'h08, 5'd29, 5'd8, 16'h0001};
    localparam logic [31:0] DIV     = {6'h00, 5'd4, 5'd5, 10'd0, 6'h1A};
    localparam logic [31:0] MFLO    = {6'h00, 10'd0, 5'd2, 5'd0, 6'h12};

`ifdef HAZ_PERF_CNT_EN
    localparam logic [31:0] EXP_STALLS = 32'd37;
`else
    localparam logic [31:0] EXP_STALLS = 32'd0;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    int n;
    int nb;

    initial begin
        rst_n      = 1'b0;
        s_rst      = 1'b0;
        instr_dec  = NOP;
        instr_exec = NOP;
        br_taken   = 1'b0;
        mem_busy   = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctl", 32'(ctl), 32'(CTL_OFF));
        check("rst_state", 32'(state), 32'd0);
        check("rst_busy", 32'(md_busy), 32'd0);
        check("rst_stall_cnt", stall_cnt, 32'd0);
        rst_n = 1'b1;

        // Load-use on rs: one bubble, then free-running
        next_cyc();
        instr_exec = LW_T0;
        instr_dec  = ADD_RS8;
        @(negedge clk);
        check("lu_ctl", 32'(ctl), 32'(CTL_STALL));
        next_cyc();
        instr_exec = NOP;
        @(negedge clk);
        check("lu_next_ctl", 32'(ctl), 32'(CTL_RUN));
        check("lu_next_state", 32'(state), 32'd3);
        next_cyc();
        instr_exec = ADD_RS8;
        instr_dec  = NOP;
        @(negedge clk);
        check("lu_done_state", 32'(state), 32'd0);
        check("lu_done_ctl", 32'(ctl), 32'(CTL_RUN));

        // DIV then MFLO: Decode held for MD_LAT-1 = 31 cycles
        next_cyc();
        instr_exec = DIV;
        instr_dec  = NOP;
        @(negedge clk);
        check("div_issue_ctl", 32'(ctl), 32'(CTL_RUN));
        check("div_issue_busy", 32'(md_busy), 32'd0);
        next_cyc();
        instr_exec = NOP;
        instr_dec  = MFLO;
        @(negedge clk);
        n  = 0;
        nb = 0;
        while (!we_dec && n < 40) begin
            n++;
            if (ctl == CTL_STALL && md_busy) nb++;
            @(negedge clk);
        end
        check("mdh_stall_cycles", 32'(n), 32'd31);
        check("mdh_stall_pattern", 32'(nb), 32'd31);
        check("mdh_release_ctl", 32'(ctl), 32'(CTL_RUN));
        check("mdh_release_busy", 32'(md_busy), 32'd0);
        check("mdh_release_state", 32'(state), 32'd1);
        next_cyc();
        instr_exec = MFLO;
        instr_dec  = NOP;
        @(negedge clk);
        check("mdh_after_state", 32'(state), 32'd0);

        // DIV with a 5-cycle memory freeze: counter keeps running
        next_cyc();
        instr_exec = DIV;
        @(negedge clk);
        check("div2_issue_ctl", 32'(ctl), 32'(CTL_RUN));
        next_cyc();
        instr_exec = NOP;
        mem_busy   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("memwait_ctl", 32'(ctl), 32'(CTL_OFF));
            if (i > 0) check("memwait_state", 32'(state), 32'd2);
            next_cyc();
        end
        mem_busy = 1'b0;
        @(negedge clk);
        check("memwait_exit_state", 32'(state), 32'd2);
        check("memwait_exit_ctl", 32'(ctl), 32'(CTL_RUN));
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("md_busy_left", 32'(n), 32'd26);
        check("stall_cnt_total", stall_cnt, EXP_STALLS);

        // Load-use through rt (store reads rt)
        next_cyc();
        instr_exec = LW_T0;
        instr_dec  = SW_RT8;
        @(negedge clk);
        check("lu_rt_ctl", 32'(ctl), 32'(CTL_STALL));
        next_cyc();
        instr_exec = NOP;
        instr_dec  = NOP;
        @(negedge clk);
        check("lu_rt_next_state", 32'(state), 32'd3);
        // ADDI writes rt rather than reading it: no hazard
        next_cyc();
        instr_exec = LW_T0;
        instr_dec  = ADDI_8;
        @(negedge clk);
        check("no_lu_addi_ctl", 32'(ctl), 32'(CTL_RUN));
        // Load into $zero never creates a hazard
        next_cyc();
        instr_exec = LW_ZERO;
        instr_dec  = ADD_RS0;
        @(negedge clk);
        check("no_lu_zero_ctl", 32'(ctl), 32'(CTL_RUN));

        // Branch and load-use together: branch wins
        next_cyc();
        instr_exec = LW_T0;
        instr_dec  = ADD_RS8;
        br_taken   = 1'b1;
        @(negedge clk);
        check("br_lu_ctl", 32'(ctl), 32'(CTL_BR));
        next_cyc();
        br_taken   = 1'b0;
        instr_exec = NOP;
        instr_dec  = NOP;
        @(negedge clk);
        check("br_lu_state", 32'(state), 32'd0);

        // Branch during memory freeze: flush waits for the first free cycle
        next_cyc();
        br_taken = 1'b1;
        mem_busy = 1'b1;
        @(negedge clk);
        check("br_busy_ctl", 32'(ctl), 32'(CTL_OFF));
        next_cyc();
        mem_busy = 1'b0;
        @(negedge clk);
        check("br_after_busy_ctl", 32'(ctl), 32'(CTL_BR));
        check("br_after_busy_state", 32'(state), 32'd2);
        next_cyc();
        br_taken = 1'b0;
        @(negedge clk);
        check("br_done_state", 32'(state), 32'd0);

        // Synchronous clear aborts a MULT/DIV wait
        next_cyc();
        instr_exec = DIV;
        @(negedge clk);
        check("srst_div_ctl", 32'(ctl), 32'(CTL_RUN));
        next_cyc();
        instr_exec = NOP;
        instr_dec  = MFLO;
        @(negedge clk);
        check("srst_pre_ctl", 32'(ctl), 32'(CTL_STALL));
        next_cyc();
        s_rst = 1'b1;
        next_cyc();
        s_rst = 1'b0;
        @(negedge clk);
        check("srst_busy", 32'(md_busy), 32'd0);
        check("srst_state", 32'(state), 32'd0);
        check("srst_ctl", 32'(ctl), 32'(CTL_RUN));
        check("srst_stall_cnt", stall_cnt, 32'd0);

        // Asynchronous reset in the middle of MD_WAIT
        next_cyc();
        instr_exec = DIV;
        instr_dec  = NOP;
        next_cyc();
        instr_exec = NOP;
        instr_dec  = MFLO;
        next_cyc();
        check("arst_pre_state", 32'(state), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_ctl", 32'(ctl), 32'(CTL_OFF));
        check("arst_state", 32'(state), 32'd0);
        check("arst_busy", 32'(md_busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cyc();
        @(negedge clk);
        check("arst_rel_state", 32'(state), 32'd0);
        check("arst_rel_busy", 32'(md_busy), 32'd0);
        check("arst_rel_ctl", 32'(ctl), 32'(CTL_RUN));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
